mem_port_arbiter: RTL

- Shares one single-port, word-addressed, synchronous-read program/data memory (256 x 32) between the core's instruction-fetch port (IF) and its load/store port (D).
- Grants at most one access per cycle, returns read data one cycle after grant, and tags each response back to its owner.
- Sits between the core (pc fetch / lw / sw) and the memory array; the memory itself holds no arbitration logic.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_prio_sel.sv | 38 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
package mem_arb_pkg;

  // Owner of the access granted last cycle, i.e. of the response returned now.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational grant selection between the fetch port and the data port.
// Build option: ARB_ROUND_ROBIN_EN selects alternating grants on conflict
// instead of data priority with a starvation limit.
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int CNT_W      = 3,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             i_if_req,
  input  logic             i_d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic             i_last_d,
`else
  input  logic [CNT_W-1:0] i_starve_cnt,
`endif
  output logic [1:0]       o_gnt
);

  // One-hot grant; a conflict is resolved by the configured policy.
  always_comb begin
    o_gnt = '0;
    if (i_if_req && i_d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i_last_d) o_gnt[GNT_IF] = 1'b1;
      else          o_gnt[GNT_D]  = 1'b1;
`else
      if (i_starve_cnt == CNT_W'(STARVE_MAX)) o_gnt[GNT_IF] = 1'b1;
      else                                   o_gnt[GNT_D]  = 1'b1;
`endif
    end else if (i_d_req) begin
      o_gnt[GNT_D] = 1'b1;
    end else if (i_if_req) begin
      o_gnt[GNT_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between the fetch port and the
// load/store port: one grant per cycle, tagged response one cycle later.
// Build option: ARB_ROUND_ROBIN_EN (alternate grants on conflict).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Requests are masked while reset is held so every output reads 0.
  logic        w_if_req;
  logic        w_d_req;
  logic [1:0]  w_gnt;
  logic        w_any_gnt;
  logic [31:0] w_sel_addr;
  logic        w_oor;

  owner_e      r_resp_owner;
  owner_e      w_owner_next;
  logic        r_oor;
  logic        r_store;

  assign w_if_req = if_req & reset_n;
  assign w_d_req  = d_req  & reset_n;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  arb_prio_sel u_sel (
    .i_if_req (w_if_req),
    .i_d_req  (w_d_req),
    .i_last_d (r_last_d),
    .o_gnt    (w_gnt)
  );

  // Remember which port won most recently; reset as if IF won last.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            r_last_d <= 1'b0;
    else if (w_gnt[GNT_D])   r_last_d <= 1'b1;
    else if (w_gnt[GNT_IF])  r_last_d <= 1'b0;
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  arb_prio_sel #(
    .CNT_W      (CNT_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .i_if_req     (w_if_req),
    .i_d_req      (w_d_req),
    .i_starve_cnt (r_starve_cnt),
    .o_gnt        (w_gnt)
  );

  // Count D grants that made a waiting fetch wait; saturate at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!w_if_req || w_gnt[GNT_IF]) begin
      r_starve_cnt <= '0;
    end else if (w_gnt[GNT_D] && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`endif

  assign if_gnt    = w_gnt[GNT_IF];
  assign d_gnt     = w_gnt[GNT_D];
  assign w_any_gnt = |w_gnt;

  // Out-of-range accesses are still granted but never reach the memory.
  assign w_sel_addr = w_gnt[GNT_D] ? d_addr : if_addr;
  assign w_oor      = w_any_gnt && (w_sel_addr[31:ADDR_W] != '0);

  assign mem_en    = w_any_gnt & ~w_oor;
  assign mem_we    = w_gnt[GNT_D] & d_we & ~w_oor;
  assign mem_addr  = w_any_gnt ? w_sel_addr[ADDR_W-1:0] : '0;
  assign mem_wdata = w_gnt[GNT_D] ? d_wdata : '0;

  // Response state register: owner, range error and store flag of last grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_owner <= OWN_NONE;
      r_oor        <= 1'b0;
      r_store      <= 1'b0;
    end else begin
      r_resp_owner <= w_owner_next;
      r_oor        <= w_oor;
      r_store      <= w_gnt[GNT_D] & d_we;
    end
  end

  // Next owner from this cycle's grant; response outputs from current owner.
  always_comb begin
    w_owner_next = OWN_NONE;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    addr_err     = 1'b0;

    if (w_gnt[GNT_D])       w_owner_next = OWN_D;
    else if (w_gnt[GNT_IF]) w_owner_next = OWN_IF;

    case (r_resp_owner)
      OWN_IF: begin
        if_rvalid = 1'b1;
        addr_err  = r_oor;
        if (!r_oor) if_rdata = mem_rdata;
      end
      OWN_D: begin
        d_rvalid = 1'b1;
        addr_err = r_oor;
        if (!r_oor && !r_store) d_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
